uart_tx_sched: RTL and testbench

//   Shares one UART transmit line between NUM_REQ byte producers. Grants the

---
 rtl/uart_tx_sched_if.sv | 23 ++
 rtl/uart_tx_sched.sv | 123 ++++++++++++
 tb/tb_uart_tx_sched.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Byte-producer request bus and serial-line status for the shared UART transmitter.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   REQ_VALID;
  logic [8*NUM_REQ-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]   REQ_READY;
  logic                 UART_TXD;
  logic                 BUSY;
  logic [IDW-1:0]       GRANT_ID;

  modport master (
    output REQ_VALID, REQ_DATA,
    input  REQ_READY, UART_TXD, BUSY, GRANT_ID
  );

  modport slave (
    input  REQ_VALID, REQ_DATA,
    output REQ_READY, UART_TXD, BUSY, GRANT_ID
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART transmit line between NUM_REQ byte producers.
module uart_tx_sched #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_REQ      = 4
) (
  input  logic           FPGA_CLK,
  input  logic           RST,
  uart_tx_sched_if.slave bus
);
  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [BW-1:0]      r_baud, w_baud_nxt;
  logic [2:0]         r_bit, w_bit_nxt;
  logic [7:0]         r_data;
  logic               r_txd, w_txd_nxt;
  logic               r_busy;
  logic [IDW-1:0]     r_grant, r_ptr;
  logic [IDW-1:0]     w_win, w_ptr_nxt;
  logic               w_found, w_accept, w_bit_end;
  logic [NUM_REQ-1:0] w_ready;

  // Search starts at the requester after the last grant and wraps.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.REQ_VALID[IDW'((32'(r_ptr) + k) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_win   = IDW'((32'(r_ptr) + k) % NUM_REQ);
      end
    end
    w_ptr_nxt = (32'(w_win) == 32'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  end

  assign w_accept = (r_state == S_IDLE) && w_found && !RST;
  assign w_ready  = w_accept ? (NUM_REQ'(1) << w_win) : '0;

  // TXD is computed one cycle ahead so the registered line lines up with the state.
  always_comb begin
    w_bit_end   = (r_baud == BAUD_MAX);
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_baud_nxt  = r_baud + 1'b1;
    w_txd_nxt   = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        if (w_accept) begin
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
        end
      end
      S_START: begin
        w_txd_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_txd_nxt   = r_data[0];
        end
      end
      S_DATA: begin
        w_txd_nxt = r_data[r_bit];
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
            w_txd_nxt = r_data[w_bit_nxt];
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_baud_nxt  = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge FPGA_CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_data  <= bus.REQ_DATA[8*w_win +: 8];
        r_grant <= w_win;
        r_ptr   <= w_ptr_nxt;
      end
    end
  end

  assign bus.REQ_READY = w_ready;
  assign bus.UART_TXD  = r_txd;
  assign bus.BUSY      = r_busy;
  assign bus.GRANT_ID  = r_grant;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with CLKS_PER_BIT=4 and four requesters.
module tb_uart_tx_sched;
  localparam int CPB = 4;
  localparam int NR  = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;
  int   t_acc;
  int   t_prev;

  uart_tx_sched_if #(.NUM_REQ(NR)) bus ();

  uart_tx_sched #(
    .CLKS_PER_BIT(CPB),
    .NUM_REQ     (NR)
  ) dut (
    .FPGA_CLK(clk),
    .RST     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a READY, checks the winner, then steps to the first start-bit cycle.
  task automatic wait_ready(input int exp_id, input string tag);
    int n;
    n = 0;
    #1;
    while (bus.REQ_READY == '0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_ready"}, 32'(bus.REQ_READY), 32'(1) << exp_id);
    t_acc = cyc;
    @(negedge clk);
    #1;
    chk({tag, "_gid"}, 32'(bus.GRANT_ID), 32'(exp_id));
  endtask

  // Checks the serial frame from frame cycle 'first' (0 = first start-bit cycle) to the idle cycle after.
  task automatic frame(input logic [7:0] b, input int first, input string tag);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = first; i < 10*CPB; i++) begin
      #1;
      chk({tag, "_txd"}, 32'(bus.UART_TXD), 32'(bits[i/CPB]));
      chk({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
      @(negedge clk);
    end
    #1;
    chk({tag, "_idle_txd"}, 32'(bus.UART_TXD), 32'd1);
    chk({tag, "_idle_busy"}, 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.REQ_VALID = '0;
    bus.REQ_DATA  = '0;

    // Reset state, and no READY while reset is held even with a request pending
    @(negedge clk);
    @(negedge clk);
    bus.REQ_VALID = 4'b0001;
    #1;
    chk("rst_ready", 32'(bus.REQ_READY), 32'd0);
    chk("rst_txd", 32'(bus.UART_TXD), 32'd1);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_gid", 32'(bus.GRANT_ID), 32'd0);

    // Test 1: single byte 0xA5
    @(negedge clk);
    bus.REQ_DATA[7:0] = 8'hA5;
    rst = 1'b0;
    wait_ready(0, "t1");
    bus.REQ_VALID = 4'b0000;
    chk("t1_ready_1cyc", 32'(bus.REQ_READY), 32'd0);
    frame(8'hA5, 0, "t1");

    // Test 2: round-robin with all requesters, 41-cycle spacing
    @(negedge clk);
    rst           = 1'b1;
    bus.REQ_VALID = 4'b1111;
    bus.REQ_DATA  = 32'h44332211;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(0, "t2_g0");
    t_prev = t_acc;
    for (int k = 1; k <= 4; k++) begin
      wait_ready(k % NR, "t2_g");
      chk("t2_spacing", 32'(t_acc - t_prev), 32'd41);
      t_prev = t_acc;
    end

    // Test 3: fairness with gaps, then a late requester 1
    rst           = 1'b1;
    bus.REQ_VALID = 4'b0101;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(0, "t3_a");
    wait_ready(2, "t3_b");
    wait_ready(0, "t3_c");
    wait_ready(2, "t3_d");
    wait_ready(0, "t3_e");
    repeat (10) @(negedge clk);
    bus.REQ_VALID = 4'b0111;
    wait_ready(1, "t3_late");

    // Test 4: reset during DATA bit 3
    rst               = 1'b1;
    bus.REQ_VALID     = 4'b0001;
    bus.REQ_DATA[7:0] = 8'hF7;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(0, "t4_first");
    bus.REQ_VALID = 4'b0101;
    repeat (17) @(negedge clk);
    #1;
    chk("t4_bit3_txd", 32'(bus.UART_TXD), 32'd0);
    rst = 1'b1;
    #1;
    chk("t4_rst_ready", 32'(bus.REQ_READY), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t4_after_txd", 32'(bus.UART_TXD), 32'd1);
    chk("t4_after_busy", 32'(bus.BUSY), 32'd0);
    chk("t4_after_ready", 32'(bus.REQ_READY), 32'd1);
    wait_ready(0, "t4_regrant");

    // Tests 5 and 6: data held after accept; withdrawn pulse during BUSY
    @(negedge clk);
    rst               = 1'b1;
    bus.REQ_VALID     = 4'b0001;
    bus.REQ_DATA[7:0] = 8'h3C;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(0, "t5");
    bus.REQ_DATA[7:0] = 8'hFF;
    bus.REQ_VALID     = 4'b0100;
    #1;
    chk("t6_busy_ready", 32'(bus.REQ_READY), 32'd0);
    @(negedge clk);
    bus.REQ_VALID = 4'b0000;
    frame(8'h3C, 1, "t5");
    chk("t6_end_ready", 32'(bus.REQ_READY), 32'd0);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("t6_stay_txd", 32'(bus.UART_TXD), 32'd1);
      chk("t6_stay_busy", 32'(bus.BUSY), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
